vga_tile_renderer: RTL and testbench
====================================

# vga_tile_renderer

Parametrised tile-map VGA renderer, successor to the hard-coded 640x480 tile display in the top level. Holds a MAP_COLS x MAP_ROWS map of TILE_BITS-wide tile codes in inferred block RAM, and exposes a write port for game logic (player movement, level loading). Generates VGA sync and maps each pixel to a tile code, then to a colour through a fixed palette. Sits between the game-state logic and the board's VGA pins.

## Interface
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 18, horizontal front porch (pixels)
- H_SYNC, 92, HSync pulse width (pixels)
- H_BACK, 50, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, VSync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- TILE_W_LOG2, 5, log2 of tile width in pixels
- TILE_H_LOG2, 5, log2 of tile height in pixels
- MAP_COLS, 20, tiles per map row
- MAP_ROWS, 15, tile rows in the map
- TILE_BITS, 4, tile code width; legal range 2..4
- COLOR_BITS, 3, bits per colour channel

Ports:
- i_Clk  in  1  pixel clock, 25 MHz
- i_Rst_L  in  1  synchronous, active-low reset
- i_Wr_En  in  1  map write strobe
- i_Wr_Col  in  clog2(MAP_COLS)  column of the write
- i_Wr_Row  in  clog2(MAP_ROWS)  row of the write
- i_Wr_Tile  in  TILE_BITS  tile code to store
- o_VGA_HSync  out  1  horizontal sync, active low
- o_VGA_VSync  out  1  vertical sync, active low
- o_VGA_Red / o_VGA_Grn / o_VGA_Blu  out  COLOR_BITS each  pixel colour
- o_Frame_Start  out  1  one-cycle pulse on the first cycle of vertical blanking

## Operation
- **Counters.** h_cnt runs 0..H_TOTAL-1 and v_cnt runs 0..V_TOTAL-1, where H_TOTAL = sum of the four H parameters and V_TOTAL likewise.
  - Count 0 is the first visible pixel. Order within a line or frame: visible, front porch, sync, back porch.
  - v_cnt advances when h_cnt wraps; both wrap to 0 together at end of frame.
- **Sync.** HSync is low for h_cnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC). VSync uses the same rule on v_cnt.
- **Tile address.** col = h_cnt >> TILE_W_LOG2, row = v_cnt >> TILE_H_LOG2, addr = row*MAP_COLS + col.
- **Colour.** Pixels outside the visible area, or with col >= MAP_COLS or row >= MAP_ROWS, render black. Otherwise colour = palette[tile code].
- **Writes.**
  - Accepted every cycle while i_Wr_En=1. Writes with an out-of-range column or row are dropped.
  - A read and a write to the same address in the same cycle returns the old data; the new code is visible from the next frame.
  - Writes are not gated by blanking. Game logic uses o_Frame_Start to update tear-free.
- **Reset.** Counters go to 0, syncs go high (inactive), colours go to 0, o_Frame_Start goes to 0, pipeline valid bits are cleared.
  - Map contents are unaffected by reset. Power-up contents are all code 0.
  - A reset asserted mid-frame restarts the frame at pixel (0,0) on the first cycle after release.

## Timing
- Pipeline depth is 3: outputs at cycle N+3 reflect counter values at cycle N.
  - Stage 1: counters and address register.
  - Stage 2: BRAM read.
  - Stage 3: palette lookup and output register.
- Sync and visible flags are delayed by the same 3 stages, so colour and sync stay aligned.
- o_Frame_Start is high for exactly one cycle per frame, 3 cycles after v_cnt reaches V_VISIBLE with h_cnt = 0.
- Default frame is 800 x 525 cycles, giving 60 Hz at 25 MHz.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **VGA_GRID_EN defined:** visible in-map pixels with (h_cnt mod tile width) == 0 or (v_cnt mod tile height) == 0 render grid colour {010,010,010}, overriding the tile colour. Latency is unchanged.
- **Undefined:** no grid logic; pixels always show the tile colour.

## Structure
- Shared package vga_pkg:
  - default timing constants;
  - 16-entry palette, entry 0 black, 1 green, 2 blue, 3 red, 4-15 per the game art list;
  - named tile codes (TILE_FLOOR, TILE_WALL, TILE_PLAYER, ...);
  - grid colour.
- Sub-module vga_timing: counters, sync generation, visible flag and o_Frame_Start source. Reused by future overlay blocks.

## Test plan
- **Reset:** hold i_Rst_L=0 for 5 cycles -> HSync=1, VSync=1, RGB=0, o_Frame_Start=0; the first visible pixel appears 3 cycles after release.
- **Sync timing:** run 2 frames -> HSync low 92 cycles per 800-cycle line; VSync low 2 lines per 525 lines; o_Frame_Start pulses exactly once per frame, period 420000 cycles.
- **Tile write:** write code 2 at col 3, row 2 -> pixels x 96..127, y 64..95 show Blu=111, Red=Grn=000; neighbouring tiles show palette[0].
- **Out-of-range write:** i_Wr_Col=20 with code 3 -> no pixel in the frame changes.
- **Mid-frame reset:** assert reset at line 200, pixel 300 -> the next frame starts at (0,0) after release; previously written tiles persist.
- **Grid (VGA_GRID_EN):** pixels at x=32 and y=32 show 010/010/010; pixel (33,33) shows the tile colour.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, tile codes, 16-entry palette
// and the grid overlay colour. Used by the tile renderer and future overlay blocks.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 18;
  localparam int DEF_H_SYNC    = 92;
  localparam int DEF_H_BACK    = 50;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } rgb_t;

  localparam logic [3:0] TILE_FLOOR  = 4'd0;
  localparam logic [3:0] TILE_GRASS  = 4'd1;
  localparam logic [3:0] TILE_WATER  = 4'd2;
  localparam logic [3:0] TILE_LAVA   = 4'd3;
  localparam logic [3:0] TILE_PLAYER = 4'd4;
  localparam logic [3:0] TILE_ENEMY  = 4'd5;
  localparam logic [3:0] TILE_ICE    = 4'd6;
  localparam logic [3:0] TILE_COIN   = 4'd7;
  localparam logic [3:0] TILE_WALL   = 4'd8;

  localparam rgb_t GRID_COLOR = 9'b010_010_010;

  function automatic rgb_t palette(input logic [3:0] code);
    rgb_t c;
    c = 9'b000_000_000;
    case (code)
      4'd0:  c = 9'b000_000_000;
      4'd1:  c = 9'b000_111_000;
      4'd2:  c = 9'b000_000_111;
      4'd3:  c = 9'b111_000_000;
      4'd4:  c = 9'b111_111_000;
      4'd5:  c = 9'b111_000_111;
      4'd6:  c = 9'b000_111_111;
      4'd7:  c = 9'b111_110_000;
      4'd8:  c = 9'b100_100_100;
      4'd9:  c = 9'b100_010_000;
      4'd10: c = 9'b011_101_000;
      4'd11: c = 9'b000_011_110;
      4'd12: c = 9'b110_011_000;
      4'd13: c = 9'b101_101_111;
      4'd14: c = 9'b011_000_011;
      4'd15: c = 9'b111_111_111;
      default: c = 9'b000_000_000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters and sync/visible/frame-start decode. All outputs are decoded
// from the registered counters, so the caller owns any further pipelining.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int HW        = 10,
  parameter int VW        = 10
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  output logic [HW-1:0] o_H_Cnt,
  output logic [VW-1:0] o_V_Cnt,
  output logic          o_HSync,
  output logic          o_VSync,
  output logic          o_Visible,
  output logic          o_Frame_Start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic [HW-1:0] r_h_cnt_p0;
  logic [VW-1:0] r_v_cnt_p0;
  logic          w_h_wrap;

  assign w_h_wrap = (r_h_cnt_p0 == HW'(H_TOTAL - 1));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_h_cnt_p0 <= '0;
      r_v_cnt_p0 <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt_p0 <= '0;
      r_v_cnt_p0 <= (r_v_cnt_p0 == VW'(V_TOTAL - 1)) ? '0 : r_v_cnt_p0 + 1'b1;
    end else begin
      r_h_cnt_p0 <= r_h_cnt_p0 + 1'b1;
    end
  end

  assign o_H_Cnt       = r_h_cnt_p0;
  assign o_V_Cnt       = r_v_cnt_p0;
  assign o_HSync       = !((r_h_cnt_p0 >= HW'(H_VISIBLE + H_FRONT)) &&
                           (r_h_cnt_p0 <  HW'(H_VISIBLE + H_FRONT + H_SYNC)));
  assign o_VSync       = !((r_v_cnt_p0 >= VW'(V_VISIBLE + V_FRONT)) &&
                           (r_v_cnt_p0 <  VW'(V_VISIBLE + V_FRONT + V_SYNC)));
  assign o_Visible     = (r_h_cnt_p0 < HW'(H_VISIBLE)) && (r_v_cnt_p0 < VW'(V_VISIBLE));
  assign o_Frame_Start = (r_v_cnt_p0 == VW'(V_VISIBLE)) && (r_h_cnt_p0 == '0);

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile-map VGA renderer: counters -> map address -> BRAM tile code -> palette, 3 stages.
// Define VGA_GRID_EN to overlay a grid line on the first pixel row/column of each tile.
module vga_tile_renderer
  import vga_pkg::*;
#(
  parameter int H_VISIBLE   = DEF_H_VISIBLE,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_VISIBLE   = DEF_V_VISIBLE,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int TILE_W_LOG2 = 5,
  parameter int TILE_H_LOG2 = 5,
  parameter int MAP_COLS    = 20,
  parameter int MAP_ROWS    = 15,
  parameter int TILE_BITS   = 4,
  parameter int COLOR_BITS  = 3
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst_L,
  input  logic                        i_Wr_En,
  input  logic [$clog2(MAP_COLS)-1:0] i_Wr_Col,
  input  logic [$clog2(MAP_ROWS)-1:0] i_Wr_Row,
  input  logic [TILE_BITS-1:0]        i_Wr_Tile,
  output logic                        o_VGA_HSync,
  output logic                        o_VGA_VSync,
  output logic [COLOR_BITS-1:0]       o_VGA_Red,
  output logic [COLOR_BITS-1:0]       o_VGA_Grn,
  output logic [COLOR_BITS-1:0]       o_VGA_Blu,
  output logic                        o_Frame_Start
);

  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
  localparam int AW        = $clog2(MAP_DEPTH);

  // Palette entries are 3 bits per channel; left-align them into the output width.
  function automatic logic [COLOR_BITS-1:0] scale_chan(input logic [2:0] c);
    logic [COLOR_BITS+2:0] wide;
    wide = {c, COLOR_BITS'(0)};
    return wide[COLOR_BITS+2 -: COLOR_BITS];
  endfunction

  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_hs, w_vs, w_visible, w_fs;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .HW(HW), .VW(VW)
  ) u_timing (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .o_H_Cnt      (w_h_cnt),
    .o_V_Cnt      (w_v_cnt),
    .o_HSync      (w_hs),
    .o_VSync      (w_vs),
    .o_Visible    (w_visible),
    .o_Frame_Start(w_fs)
  );

  logic [HW-1:0] w_col;
  logic [VW-1:0] w_row;
  logic          w_in_map;
  logic [AW-1:0] w_rd_addr;
  logic          w_wr_ok;
  logic [AW-1:0] w_wr_addr;

  assign w_col     = w_h_cnt >> TILE_W_LOG2;
  assign w_row     = w_v_cnt >> TILE_H_LOG2;
  assign w_in_map  = w_visible && (int'(w_col) < MAP_COLS) && (int'(w_row) < MAP_ROWS);
  assign w_rd_addr = w_in_map ? AW'(int'(w_row) * MAP_COLS + int'(w_col)) : '0;
  assign w_wr_ok   = i_Wr_En && (int'(i_Wr_Col) < MAP_COLS) && (int'(i_Wr_Row) < MAP_ROWS);
  assign w_wr_addr = AW'(int'(i_Wr_Row) * MAP_COLS + int'(i_Wr_Col));

`ifdef VGA_GRID_EN
  logic w_grid;
  logic r_grid_p1, r_grid_p2;
  assign w_grid = (w_h_cnt[TILE_W_LOG2-1:0] == '0) || (w_v_cnt[TILE_H_LOG2-1:0] == '0);
`endif

  logic [TILE_BITS-1:0] r_map [MAP_DEPTH];
  logic [AW-1:0]        r_addr_p1;
  logic [TILE_BITS-1:0] r_tile_p2;
  logic                 r_vld_p1, r_hs_p1, r_vs_p1, r_fs_p1;
  logic                 r_vld_p2, r_hs_p2, r_vs_p2, r_fs_p2;
  logic                 r_hs_p3, r_vs_p3, r_fs_p3;
  logic [COLOR_BITS-1:0] r_red_p3, r_grn_p3, r_blu_p3;

  // Stage 1 (address) and stage 2 (BRAM read): data path, no reset.
  // The read sees the pre-write contents when it collides with a write.
  always_ff @(posedge i_Clk) begin
    if (w_wr_ok) r_map[w_wr_addr] <= i_Wr_Tile;
    r_addr_p1 <= w_rd_addr;
    r_tile_p2 <= r_map[r_addr_p1];
`ifdef VGA_GRID_EN
    r_grid_p1 <= w_grid;
    r_grid_p2 <= r_grid_p1;
`endif
  end

  // Stages 1-2: control flags travelling alongside the tile data.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_vld_p1 <= 1'b0; r_hs_p1 <= 1'b1; r_vs_p1 <= 1'b1; r_fs_p1 <= 1'b0;
      r_vld_p2 <= 1'b0; r_hs_p2 <= 1'b1; r_vs_p2 <= 1'b1; r_fs_p2 <= 1'b0;
    end else begin
      r_vld_p1 <= w_in_map; r_hs_p1 <= w_hs;    r_vs_p1 <= w_vs;    r_fs_p1 <= w_fs;
      r_vld_p2 <= r_vld_p1; r_hs_p2 <= r_hs_p1; r_vs_p2 <= r_vs_p1; r_fs_p2 <= r_fs_p1;
    end
  end

  rgb_t w_pix;

  always_comb begin
    w_pix = palette(4'(r_tile_p2));
`ifdef VGA_GRID_EN
    if (r_grid_p2) w_pix = GRID_COLOR;
`endif
  end

  // Stage 3: palette lookup and output register.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_hs_p3  <= 1'b1;
      r_vs_p3  <= 1'b1;
      r_fs_p3  <= 1'b0;
      r_red_p3 <= '0;
      r_grn_p3 <= '0;
      r_blu_p3 <= '0;
    end else begin
      r_hs_p3  <= r_hs_p2;
      r_vs_p3  <= r_vs_p2;
      r_fs_p3  <= r_fs_p2;
      r_red_p3 <= r_vld_p2 ? scale_chan(w_pix.r) : '0;
      r_grn_p3 <= r_vld_p2 ? scale_chan(w_pix.g) : '0;
      r_blu_p3 <= r_vld_p2 ? scale_chan(w_pix.b) : '0;
    end
  end

  assign o_VGA_HSync   = r_hs_p3;
  assign o_VGA_VSync   = r_vs_p3;
  assign o_Frame_Start = r_fs_p3;
  assign o_VGA_Red     = r_red_p3;
  assign o_VGA_Grn     = r_grn_p3;
  assign o_VGA_Blu     = r_blu_p3;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Scoreboard bench for vga_tile_renderer on a reduced raster (136x82, 8x8 tiles,
// 12x8 map with off-map columns/rows in the visible area) to keep frames short.
module tb_vga_tile_renderer;

  localparam int HV = 112, HF = 4, HS = 12, HB = 8;
  localparam int VV = 72,  VF = 3, VS = 2,  VB = 5;
  localparam int TW = 3, TH = 3, MC = 12, MR = 8;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [11:0] RST_VEC = 12'b110_000_000_000;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic       i_Wr_En;
  logic [3:0] i_Wr_Col;
  logic [2:0] i_Wr_Row;
  logic [3:0] i_Wr_Tile;
  logic       o_VGA_HSync, o_VGA_VSync, o_Frame_Start;
  logic [2:0] o_VGA_Red, o_VGA_Grn, o_VGA_Blu;

  vga_tile_renderer #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .TILE_W_LOG2(TW), .TILE_H_LOG2(TH), .MAP_COLS(MC), .MAP_ROWS(MR),
    .TILE_BITS(4), .COLOR_BITS(3)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_Wr_En      (i_Wr_En),
    .i_Wr_Col     (i_Wr_Col),
    .i_Wr_Row     (i_Wr_Row),
    .i_Wr_Tile    (i_Wr_Tile),
    .o_VGA_HSync  (o_VGA_HSync),
    .o_VGA_VSync  (o_VGA_VSync),
    .o_VGA_Red    (o_VGA_Red),
    .o_VGA_Grn    (o_VGA_Grn),
    .o_VGA_Blu    (o_VGA_Blu),
    .o_Frame_Start(o_Frame_Start)
  );

  always #5 i_Clk = ~i_Clk;

  logic [11:0] dut_out;
  assign dut_out = {o_VGA_HSync, o_VGA_VSync, o_Frame_Start, o_VGA_Red, o_VGA_Grn, o_VGA_Blu};

  int          n_vec = 0;
  int          n_err = 0;
  int          mh, mv;
  int          cyc = 0;
  int          last_fs = -1;
  int          hs_low, vs_low, fs_cnt;
  logic [3:0]  mmap [MR][MC];
  logic [11:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (model h=%0d v=%0d)", tag, got, exp, mh, mv);
    end
  endtask

  function automatic logic [8:0] pal(input logic [3:0] code);
    case (code)
      4'd0:    return 9'b000_000_000;
      4'd1:    return 9'b000_111_000;
      4'd2:    return 9'b000_000_111;
      4'd3:    return 9'b111_000_000;
      default: return 9'b111_111_111;
    endcase
  endfunction

  function automatic logic [11:0] exp_pix(input int h, input int v);
    logic       hs, vs, fs;
    logic [8:0] rgb;
    int         c, r;
    hs  = !(h >= HV + HF && h < HV + HF + HS);
    vs  = !(v >= VV + VF && v < VV + VF + VS);
    fs  = (v == VV) && (h == 0);
    rgb = '0;
    c   = h / (1 << TW);
    r   = v / (1 << TH);
    if (h < HV && v < VV && c < MC && r < MR) begin
      rgb = pal(mmap[r][c]);
`ifdef VGA_GRID_EN
      if ((h % (1 << TW)) == 0 || (v % (1 << TH)) == 0) rgb = 9'b010_010_010;
`endif
    end
    return {hs, vs, fs, rgb};
  endfunction

  task automatic set_wr(input int col, input int row, input int code);
    i_Wr_En   = 1'b1;
    i_Wr_Col  = 4'(col);
    i_Wr_Row  = 3'(row);
    i_Wr_Tile = 4'(code);
    if (col < MC && row < MR) mmap[row][col] = 4'(code);
  endtask

  task automatic rst_cycle();
    @(posedge i_Clk); #1;
    chk("reset", 32'(dut_out), 32'(RST_VEC));
    i_Wr_En = 1'b0;
  endtask

  task automatic release_rst();
    i_Rst_L = 1'b1;
    mh = 0;
    mv = 0;
    last_fs = -1;
    sb.delete();
    sb.push_back(RST_VEC);
    sb.push_back(RST_VEC);
    sb.push_back(exp_pix(0, 0));
  endtask

  task automatic step();
    logic [11:0] e;
    @(posedge i_Clk); #1;
    cyc++;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    sb.push_back(exp_pix(mh, mv));
    e = sb.pop_front();
    chk("pixel", 32'(dut_out), 32'(e));
    if (!o_VGA_HSync) hs_low++;
    if (!o_VGA_VSync) vs_low++;
    if (o_Frame_Start) begin
      fs_cnt++;
      if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(FRAME));
      last_fs = cyc;
    end
    i_Wr_En = 1'b0;
  endtask

  task automatic run_to(input int v, input int h);
    int n;
    n = 0;
    while (!(mv == v && mh == h) && n < FRAME + 8) begin
      step();
      n++;
    end
  endtask

  initial begin
    i_Rst_L   = 1'b0;
    i_Wr_En   = 1'b0;
    i_Wr_Col  = '0;
    i_Wr_Row  = '0;
    i_Wr_Tile = '0;
    mh = 0; mv = 0;
    hs_low = 0; vs_low = 0; fs_cnt = 0;

    // Load an all-floor level while reset is held; outputs must stay idle.
    for (int r = 0; r < MR; r++)
      for (int c = 0; c < MC; c++) begin
        set_wr(c, r, 0);
        rst_cycle();
      end
    release_rst();

    // Frame 1 is blank; place tiles during its vertical blanking.
    run_to(VV, 0);
    repeat (10) step();
    set_wr(3, 2, 2);   step();
    set_wr(0, 0, 1);   step();
    set_wr(11, 7, 3);  step();
    set_wr(5, 4, 3);   step();
    set_wr(12, 0, 3);  step();
    set_wr(15, 5, 3);  step();

    // Frame 2 shows the tiles; sync totals over one full frame window.
    run_to(0, 0);
    hs_low = 0; vs_low = 0; fs_cnt = 0;
    repeat (FRAME) step();
    chk("hsync_low_cycles", 32'(hs_low), 32'(VT * HS));
    chk("vsync_low_cycles", 32'(vs_low), 32'(VS * HT));
    chk("frame_start_count", 32'(fs_cnt), 32'd1);

    // Mid-frame reset: restart at (0,0), tiles must persist.
    run_to(40, 60);
    i_Rst_L = 1'b0;
    repeat (4) rst_cycle();
    release_rst();
    fs_cnt = 0;
    repeat (FRAME + 16) step();
    chk("frame_start_after_reset", 32'(fs_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
